out_ram_reader: RTL

- Drains the product memory after the multiplier datapath has finished writing it.
- On start, reads NUM_WORDS 32-bit products from the output RAM read port, address 0 upward.
- Serialises each product into bytes, MSB first, on a valid/ready byte stream.
- Sits between the output RAM and the chip-level byte transmitter.

---
 rtl/out_ram_reader_if.sv | 25 ++
 rtl/out_ram_reader.sv | 113 +++++++++++
 2 files changed

// File: rtl/out_ram_reader_if.sv
// Bundles the output-RAM read port and the outgoing byte stream of out_ram_reader.
// The master is the reader; the slave side is the RAM plus the byte consumer.
interface out_ram_reader_if #(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BYTE_WIDTH = 8
);
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [BYTE_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  tx_last;

   modport master (
      output rd_en, rd_addr, tx_data, tx_valid, tx_last,
      input  rd_data, tx_ready
   );

   modport slave (
      input  rd_en, rd_addr, tx_data, tx_valid, tx_last,
      output rd_data, tx_ready
   );
endinterface

// File: rtl/out_ram_reader.sv
// Reads NUM_WORDS products from the output RAM (address 0 upward) and streams
// each one out MSB-first as BYTE_WIDTH-wide bytes on a valid/ready interface.
module out_ram_reader #(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned NUM_WORDS  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   out_ram_reader_if.master  bus,
   output logic              busy,
   output logic              done
);
   localparam int unsigned BytesPerWord = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned ByteCntW     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
   localparam int unsigned WordCntW     = ADDR_WIDTH + 1;
   localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(BytesPerWord - 1);
   localparam logic [WordCntW-1:0] LastWord = WordCntW'(NUM_WORDS - 1);

   typedef enum logic [2:0] {StIdle, StRead, StLoad, StSend, StFin} state_e;

   state_e                state_q, state_d;
   logic [WordCntW-1:0]   word_cnt_q, word_cnt_d;
   logic [ByteCntW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

   logic handshake;
   logic last_byte;
   logic last_word;

   assign handshake = (state_q == StSend) && bus.tx_ready;
   assign last_byte = (byte_cnt_q == LastByte);
   assign last_word = (word_cnt_q == LastWord);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StRead;
         StRead: state_d = abort ? StIdle : StLoad;
         StLoad: state_d = abort ? StIdle : StSend;
         StSend: begin
            if (abort) begin
               state_d = StIdle;
            end else if (handshake && last_byte) begin
               state_d = last_word ? StFin : StRead;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      word_cnt_d = word_cnt_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      rd_addr_d  = rd_addr_q;
      if (state_q == StIdle && start) begin
         word_cnt_d = '0;
      end
      if (state_q == StLoad) begin
         shift_d    = bus.rd_data;
         byte_cnt_d = '0;
      end
      if (handshake) begin
         shift_d    = shift_q << BYTE_WIDTH;
         byte_cnt_d = byte_cnt_q + 1'b1;
         if (last_byte && !last_word) begin
            word_cnt_d = word_cnt_q + 1'b1;
         end
      end
      // Address is registered on READ entry so it holds its value outside READ.
      if (state_d == StRead) begin
         rd_addr_d = word_cnt_d[ADDR_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_cnt_q <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         rd_addr_q  <= '0;
      end else begin
         word_cnt_q <= word_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         rd_addr_q  <= rd_addr_d;
      end
   end

   always_comb begin
      bus.rd_en    = (state_q == StRead);
      bus.rd_addr  = rd_addr_q;
      bus.tx_valid = (state_q == StSend);
      bus.tx_data  = bus.tx_valid ? shift_q[DATA_WIDTH-1 -: BYTE_WIDTH] : '0;
      bus.tx_last  = bus.tx_valid && last_byte && last_word;
      busy         = (state_q == StRead) || (state_q == StLoad) || (state_q == StSend);
      done         = (state_q == StFin);
   end
endmodule
